// File: rtl/fetch_stage.sv
// Instruction fetch stage: keeps one imem request in flight, absorbs hazard stalls
// and redirects, and feeds the IF/ID pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        validD,
  output logic        fetch_busy
);

  localparam logic [1:0] FETCH   = 2'd0;
  localparam logic [1:0] WAIT    = 2'd1;
  localparam logic [1:0] HOLD    = 2'd2;
  localparam logic [1:0] DISCARD = 2'd3;

  logic [1:0]  stateReg, stateNext;
  logic [31:0] pcReg, pcNext;
  logic [31:0] holdReg, holdNext;
  logic        deliver;
  logic [31:0] deliverWord;
  logic [31:0] pcPlus4;

  assign pcPlus4 = pcReg + 32'd4;

  always_comb begin
    stateNext   = stateReg;
    pcNext      = pcReg;
    holdNext    = holdReg;
    deliver     = 1'b0;
    deliverWord = imem_rdata;
    case (stateReg)
      FETCH: begin
        if (PCSrcE) pcNext = PCTargetE;
        else if (!stallF) stateNext = WAIT;
      end
      WAIT: begin
        if (imem_valid) begin
          if (PCSrcE) begin
            pcNext    = PCTargetE;
            stateNext = FETCH;
          end else if (!stallD) begin
            deliver   = 1'b1;
            pcNext    = pcPlus4;
            stateNext = FETCH;
          end else begin
            holdNext  = imem_rdata;
            stateNext = HOLD;
          end
        end else if (PCSrcE) begin
          // Response still in flight for the old path; it must be swallowed.
          pcNext    = PCTargetE;
          stateNext = DISCARD;
        end
      end
      HOLD: begin
        if (PCSrcE) begin
          pcNext    = PCTargetE;
          stateNext = FETCH;
        end else if (!stallD) begin
          deliver     = 1'b1;
          deliverWord = holdReg;
          pcNext      = pcPlus4;
          stateNext   = FETCH;
        end
      end
      DISCARD: begin
        if (PCSrcE) pcNext = PCTargetE;
        if (imem_valid) stateNext = FETCH;
      end
      default: stateNext = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg <= FETCH;
      pcReg    <= RESET_PC;
      holdReg  <= 32'd0;
    end else begin
      stateReg <= stateNext;
      pcReg    <= pcNext;
      holdReg  <= holdNext;
    end
  end

  // IF/ID register: flush beats stall beats delivery; anything else is a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      InstrD   <= NOP_INSTR;
      PCD      <= 32'd0;
      PCPlus4D <= 32'd0;
      validD   <= 1'b0;
    end else if (flushD) begin
      InstrD   <= NOP_INSTR;
      PCD      <= 32'd0;
      PCPlus4D <= 32'd0;
      validD   <= 1'b0;
    end else if (stallD) begin
      InstrD   <= InstrD;
      PCD      <= PCD;
      PCPlus4D <= PCPlus4D;
      validD   <= validD;
    end else if (deliver) begin
      InstrD   <= deliverWord;
      PCD      <= pcReg;
      PCPlus4D <= pcPlus4;
      validD   <= 1'b1;
    end else begin
      InstrD   <= NOP_INSTR;
      PCD      <= 32'd0;
      PCPlus4D <= 32'd0;
      validD   <= 1'b0;
    end
  end

  assign imem_req   = (stateReg == FETCH) & ~stallF & ~PCSrcE & ~reset;
  assign imem_addr  = pcReg;
  assign fetch_busy = (stateReg == FETCH) | (stateReg == DISCARD) |
                      ((stateReg == WAIT) & ~imem_valid);

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized hazard/redirect stimulus against a transaction-level fetch model,
// with a latency-randomizing instruction memory and a reset-during-request scenario.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stallF, stallD, flushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        validD;
  logic        fetch_busy;

  int nChecks = 0;
  int nPass   = 0;

  // Reference model: program counter plus "what is outstanding" flags.
  logic [31:0] mPc;
  bit          mOut, mDrop, mHold;
  logic [31:0] eInstr, ePC, ePC4;
  logic        eValid;

  // Memory model: a single response slot with a countdown.
  bit          respPending = 1'b0;
  logic [31:0] respAddr;
  int          respCnt;

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .reset(reset), .stallF(stallF), .stallD(stallD), .flushD(flushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .InstrD(InstrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .validD(validD), .fetch_busy(fetch_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic modelReset();
    mPc = RESET_PC; mOut = 0; mDrop = 0; mHold = 0;
    eInstr = NOP_INSTR; ePC = 0; ePC4 = 0; eValid = 0;
    respPending = 0;
  endtask

  task automatic driveInputs(input bit rnd);
    if (rnd) begin
      stallF = ($urandom % 5) == 0;
      stallD = ($urandom % 4) == 0;
      flushD = ($urandom % 10) == 0;
      PCSrcE = ($urandom % 10) == 0;
      case ($urandom % 4)
        0:       PCTargetE = 32'hFFFF_FFFC;
        1:       PCTargetE = 32'h0000_0100;
        default: PCTargetE = $urandom & 32'hFFFF_FFFC;
      endcase
    end else begin
      stallF = 0; stallD = 0; flushD = 0; PCSrcE = 0; PCTargetE = 32'h0;
    end
    imem_valid = 0;
    imem_rdata = $urandom;
    if (respPending) begin
      respCnt--;
      if (respCnt == 0) begin
        imem_valid  = 1;
        imem_rdata  = memWord(respAddr);
        respPending = 0;
      end
    end else if (rnd && !mOut && ($urandom % 8) == 0) begin
      imem_valid = 1;  // unsolicited strobe: must be ignored
    end
  endtask

  // One clock: check combinational outputs mid-cycle, advance model, check IF/ID after the edge.
  task automatic step();
    bit          dlv;
    logic [31:0] dPc;
    @(negedge clk);
    checkVal("imem_req", imem_req, !mOut && !mHold && !stallF && !PCSrcE);
    checkVal("imem_addr", imem_addr, mPc);
    checkVal("fetch_busy", fetch_busy, mHold ? 1'b0 : ((mOut && !mDrop) ? !imem_valid : 1'b1));

    dlv = 0; dPc = mPc;
    if (mHold) begin
      if (PCSrcE) begin mHold = 0; mPc = PCTargetE; end
      else if (!stallD) begin dlv = 1; mHold = 0; mPc = mPc + 4; end
    end else if (mOut && mDrop) begin
      if (PCSrcE) mPc = PCTargetE;
      if (imem_valid) begin mOut = 0; mDrop = 0; end
    end else if (mOut) begin
      if (imem_valid) begin
        mOut = 0;
        if (PCSrcE) mPc = PCTargetE;
        else if (!stallD) begin dlv = 1; mPc = mPc + 4; end
        else mHold = 1;
      end else if (PCSrcE) begin
        mPc = PCTargetE; mDrop = 1;
      end
    end else begin
      if (PCSrcE) mPc = PCTargetE;
      else if (!stallF) mOut = 1;
    end

    if (flushD) begin
      eInstr = NOP_INSTR; ePC = 0; ePC4 = 0; eValid = 0;
    end else if (!stallD) begin
      if (dlv) begin
        eInstr = memWord(dPc); ePC = dPc; ePC4 = dPc + 32'd4; eValid = 1;
      end else begin
        eInstr = NOP_INSTR; ePC = 0; ePC4 = 0; eValid = 0;
      end
    end

    if (imem_req === 1'b1) begin
      respPending = 1;
      respAddr    = imem_addr;
      respCnt     = $urandom_range(3, 1);
    end

    @(posedge clk); #1;
    checkVal("InstrD", InstrD, eInstr);
    checkVal("PCD", PCD, ePC);
    checkVal("PCPlus4D", PCPlus4D, ePC4);
    checkVal("validD", validD, eValid);
  endtask

  initial begin
    bit found;
    reset = 1;
    stallF = 0; stallD = 0; flushD = 0; PCSrcE = 0; PCTargetE = 0;
    imem_valid = 0; imem_rdata = 0;
    modelReset();
    #3;
    checkVal("rst_imem_req", imem_req, 0);
    checkVal("rst_imem_addr", imem_addr, RESET_PC);
    checkVal("rst_InstrD", InstrD, NOP_INSTR);
    checkVal("rst_validD", validD, 0);
    checkVal("rst_PCD", PCD, 0);
    checkVal("rst_PCPlus4D", PCPlus4D, 0);
    repeat (2) @(posedge clk);
    #1 reset = 0;

    for (int i = 0; i < 3000; i++) begin
      driveInputs(1);
      step();
    end

    // Get a request in flight, then reset before its response returns.
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      driveInputs(0);
      step();
      if (mOut && !mDrop && respPending) found = 1;
    end
    checkVal("reached_wait", found, 1);
    reset = 1;
    #1;
    checkVal("async_rst_InstrD", InstrD, NOP_INSTR);
    checkVal("async_rst_validD", validD, 0);
    checkVal("async_rst_addr", imem_addr, RESET_PC);
    checkVal("async_rst_req", imem_req, 0);
    @(posedge clk); #1;
    reset = 0;
    modelReset();
    driveInputs(0);
    imem_valid = 1;          // stale response to the abandoned request
    imem_rdata = 32'hDEAD_BEEF;
    step();

    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      driveInputs(0);
      step();
      if (validD === 1'b1) found = 1;
    end
    checkVal("post_rst_delivery", found, 1);
    if (found) begin
      checkVal("post_rst_InstrD", InstrD, memWord(RESET_PC));
      checkVal("post_rst_PCD", PCD, RESET_PC);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
